// File: rtl/mux_pkg.sv
// Shared types and constants for the N:1 word selector family.
// Provides the skid FSM state encoding and the default word width.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } mux_state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/mux_n_comb.sv
// Pure combinational N:1 word selector; out-of-range select gives zero.
// Ports: data (N flattened words), sel, word (selected), bad (sel >= N).
module mux_n_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 6,
  parameter int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   word,
  output logic               bad
);

  // Equality against each legal code avoids a constant
  // compare when N is a power of two.
  always_comb begin
    word = '0;
    bad  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == k[SELW-1:0]) begin
        word = data[k*WIDTH +: WIDTH];
        bad  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 word selector with registered valid/ready output and 2-entry skid.
// Ports: CLK, RST_N, in_* producer side, out_* consumer side, err_* status.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 6,
  parameter int ERRW  = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               err_clr,
  output logic               sel_err,
  output logic [ERRW-1:0]    err_cnt
);

  mux_state_t       state_q;
  mux_state_t       state_d;
  logic             rdy_q;
  logic [WIDTH-1:0] main_data;
  logic [SELW-1:0]  main_sel;
  logic [WIDTH-1:0] skid_data;
  logic [SELW-1:0]  skid_sel;
  logic             err_q;
  logic [ERRW-1:0]  cnt_q;

  logic [WIDTH-1:0] word;
  logic             bad;
  logic             acc;
  logic             pop;
  logic             ill;
  logic             ld_in;
  logic             ld_skid;
  logic             ld_from_skid;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N     (N),
    .SELW  (SELW)
  ) u_sel (
    .data (in_data),
    .sel  (in_sel),
    .word (word),
    .bad  (bad)
  );

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = rdy_q;
  assign out_data  = main_data;
  assign out_sel   = main_sel;
  assign sel_err   = err_q;
  assign err_cnt   = cnt_q;

  assign acc = in_valid && rdy_q;
  assign pop = out_valid && out_ready;
  // Gated by acc so an X select on an idle cycle never reaches state.
  assign ill = acc && bad;

  always_comb begin
    state_d      = state_q;
    ld_in        = 1'b0;
    ld_skid      = 1'b0;
    ld_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          ld_in   = 1'b1;
        end
      end
      ONE: begin
        if (acc && pop) begin
          ld_in = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end else if (acc) begin
          state_d = FULL;
          ld_skid = 1'b1;
        end
      end
      FULL: begin
        if (pop) begin
          state_d      = ONE;
          ld_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= EMPTY;
      rdy_q     <= 1'b0;
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      state_q <= state_d;
      // Registered ready: never a combinational path from out_ready.
      rdy_q   <= (state_d != FULL);
      if (ld_in) begin
        main_data <= word;
        main_sel  <= in_sel;
      end else if (ld_from_skid) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
      end
      if (ld_skid) begin
        skid_data <= word;
        skid_sel  <= in_sel;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (err_clr) begin
      // Clear wins, but a same-cycle illegal accept still counts.
      err_q <= ill;
      cnt_q <= ill ? ERRW'(1) : '0;
    end else if (ill) begin
      err_q <= 1'b1;
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + ERRW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and scoreboard bench for mux_n_pipe across several parameter sets.
// Drives inputs 1 time unit after the rising edge; samples there too.
module tb_mux_n_pipe;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Shared stimulus for the N=6/W=32 pair (ERRW=8 and ERRW=2)
  logic [6*32-1:0] a_data;
  logic [2:0]      a_sel;
  logic            a_valid, a_ordy, a_clr;
  logic            a_irdy, a_ovalid, a_err;
  logic [31:0]     a_odata;
  logic [2:0]      a_osel;
  logic [7:0]      a_cnt;
  logic            s_irdy, s_ovalid, s_err;
  logic [31:0]     s_odata;
  logic [2:0]      s_osel;
  logic [1:0]      s_cnt;

  // N=2, WIDTH=1
  logic [1:0] b_data;
  logic [0:0] b_sel, b_osel, b_odata;
  logic       b_valid, b_ordy, b_irdy, b_ovalid, b_err;
  logic [7:0] b_cnt;

  // N=64, WIDTH=64
  logic [64*64-1:0] c_data;
  logic [5:0]       c_sel, c_osel;
  logic [63:0]      c_odata;
  logic             c_valid, c_ordy, c_irdy, c_ovalid, c_err;
  logic [7:0]       c_cnt;

  mux_n_pipe #(.WIDTH(32), .N(6), .ERRW(8)) d0 (
    .CLK(CLK), .RST_N(RST_N),
    .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid), .in_ready(a_irdy),
    .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovalid),
    .out_ready(a_ordy), .err_clr(a_clr), .sel_err(a_err), .err_cnt(a_cnt)
  );

  mux_n_pipe #(.WIDTH(32), .N(6), .ERRW(2)) d1 (
    .CLK(CLK), .RST_N(RST_N),
    .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid), .in_ready(s_irdy),
    .out_data(s_odata), .out_sel(s_osel), .out_valid(s_ovalid),
    .out_ready(a_ordy), .err_clr(a_clr), .sel_err(s_err), .err_cnt(s_cnt)
  );

  mux_n_pipe #(.WIDTH(1), .N(2), .ERRW(8)) d2 (
    .CLK(CLK), .RST_N(RST_N),
    .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid), .in_ready(b_irdy),
    .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ovalid),
    .out_ready(b_ordy), .err_clr(1'b0), .sel_err(b_err), .err_cnt(b_cnt)
  );

  mux_n_pipe #(.WIDTH(64), .N(64), .ERRW(8)) d3 (
    .CLK(CLK), .RST_N(RST_N),
    .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid), .in_ready(c_irdy),
    .out_data(c_odata), .out_sel(c_osel), .out_valid(c_ovalid),
    .out_ready(c_ordy), .err_clr(1'b0), .sel_err(c_err), .err_cnt(c_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [63:0] q2_d[$];
  int          q2_s[$];
  logic [63:0] q3_d[$];
  int          q3_s[$];

  initial begin
    RST_N = 1'b0;
    a_valid = 1'b0; a_ordy = 1'b0; a_clr = 1'b0; a_sel = '0;
    b_valid = 1'b0; b_ordy = 1'b0; b_sel = '0; b_data = '0;
    c_valid = 1'b0; c_ordy = 1'b0; c_sel = '0; c_data = '0;
    for (int k = 0; k < 6; k++) a_data[k*32 +: 32] = 32'h1000_0000 + k;

    // Reset state
    tick();
    tick();
    chk("rst_ovalid", a_ovalid, 0);
    chk("rst_irdy", a_irdy, 0);
    chk("rst_odata", a_odata, 0);
    chk("rst_osel", a_osel, 0);
    chk("rst_err", a_err, 0);
    chk("rst_cnt", a_cnt, 0);
    RST_N = 1'b1;
    tick();
    chk("rel_irdy", a_irdy, 1);
    chk("rel_ovalid", a_ovalid, 0);

    // Streaming sel 0..5, no gaps
    a_ordy = 1'b1;
    a_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_sel = 3'(i);
      tick();
      chk("str_ovalid", a_ovalid, 1);
      chk("str_odata", a_odata, 64'(32'h1000_0000 + i));
      chk("str_osel", a_osel, i);
    end
    a_valid = 1'b0;
    tick();
    chk("str_drain", a_ovalid, 0);

    // Back-pressure: two held, third refused
    a_ordy = 1'b0;
    a_valid = 1'b1;
    a_sel = 3'd2;
    tick();
    chk("bp1_irdy", a_irdy, 1);
    chk("bp1_odata", a_odata, 32'h1000_0002);
    a_sel = 3'd3;
    tick();
    chk("bp2_irdy", a_irdy, 0);
    chk("bp2_odata", a_odata, 32'h1000_0002);
    a_sel = 3'd4;
    tick();
    chk("bp3_irdy", a_irdy, 0);
    chk("bp3_ovalid", a_ovalid, 1);
    chk("bp3_odata", a_odata, 32'h1000_0002);
    chk("bp3_osel", a_osel, 2);
    a_valid = 1'b0;
    a_ordy = 1'b1;
    tick();
    chk("bp4_odata", a_odata, 32'h1000_0003);
    chk("bp4_osel", a_osel, 3);
    chk("bp4_irdy", a_irdy, 1);
    tick();
    chk("bp5_ovalid", a_ovalid, 0);

    // Illegal selects 6 and 7
    a_valid = 1'b1;
    a_sel = 3'd6;
    tick();
    chk("ill6_odata", a_odata, 0);
    chk("ill6_osel", a_osel, 6);
    chk("ill6_err", a_err, 1);
    chk("ill6_cnt", a_cnt, 1);
    a_sel = 3'd7;
    tick();
    chk("ill7_odata", a_odata, 0);
    chk("ill7_osel", a_osel, 7);
    chk("ill7_cnt", a_cnt, 2);
    chk("ill7_scnt", s_cnt, 2);
    a_valid = 1'b0;

    // Clear, then saturate the 2-bit counter
    a_clr = 1'b1;
    tick();
    chk("clr_err", a_err, 0);
    chk("clr_cnt", a_cnt, 0);
    chk("clr_scnt", s_cnt, 0);
    a_clr = 1'b0;
    a_valid = 1'b1;
    a_sel = 3'd6;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_scnt", s_cnt, 3);
    chk("sat_serr", s_err, 1);
    chk("sat_acnt", a_cnt, 5);
    chk("sat_odata", s_odata, 0);
    a_clr = 1'b1;
    a_sel = 3'd7;
    tick();
    chk("clrill_scnt", s_cnt, 1);
    chk("clrill_serr", s_err, 1);
    chk("clrill_acnt", a_cnt, 1);
    chk("clrill_osel", a_osel, 7);
    a_clr = 1'b0;
    a_valid = 1'b0;
    tick();

    // X on an unaccepted select
    a_sel = 'x;
    tick();
    chk("x_ovalid", a_ovalid, 0);
    chk("x_cnt", a_cnt, 1);

    // Reset mid-stream with A, B in flight
    a_ordy = 1'b0;
    a_valid = 1'b1;
    a_sel = 3'd0;
    tick();
    a_sel = 3'd1;
    tick();
    chk("mid_full", a_irdy, 0);
    #3;
    RST_N = 1'b0;
    #1;
    chk("mid_ovalid", a_ovalid, 0);
    chk("mid_cnt", a_cnt, 0);
    chk("mid_err", a_err, 0);
    chk("mid_irdy", a_irdy, 0);
    chk("mid_odata", a_odata, 0);
    a_valid = 1'b0;
    #1;
    RST_N = 1'b1;
    tick();
    chk("mid_rel_irdy", a_irdy, 1);
    chk("mid_rel_ovalid", a_ovalid, 0);
    a_ordy = 1'b1;
    tick();
    chk("mid_noemit1", a_ovalid, 0);
    tick();
    chk("mid_noemit2", a_ovalid, 0);

    // Random traffic on N=2/W=1 and N=64/W=64 against a scoreboard
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc < 250) begin
        b_valid = 1'($urandom_range(0, 1));
        b_sel = 1'($urandom_range(0, 1));
        b_data = 2'($urandom);
        b_ordy = ($urandom_range(0, 3) != 0);
        c_valid = 1'($urandom_range(0, 1));
        c_sel = 6'($urandom_range(0, 63));
        for (int k = 0; k < 128; k++) c_data[k*32 +: 32] = $urandom;
        c_ordy = ($urandom_range(0, 3) != 0);
      end else begin
        b_valid = 1'b0;
        b_ordy = 1'b1;
        c_valid = 1'b0;
        c_ordy = 1'b1;
      end
      if (b_ovalid && b_ordy) begin
        chk("b_nonempty", q2_d.size() != 0, 1);
        if (q2_d.size() != 0) begin
          chk("b_data", b_odata, q2_d.pop_front());
          chk("b_sel", b_osel, q2_s.pop_front());
        end
      end
      if (c_ovalid && c_ordy) begin
        chk("c_nonempty", q3_d.size() != 0, 1);
        if (q3_d.size() != 0) begin
          chk("c_data", c_odata, q3_d.pop_front());
          chk("c_sel", c_osel, q3_s.pop_front());
        end
      end
      if (b_valid && b_irdy) begin
        q2_d.push_back(64'(b_data[b_sel]));
        q2_s.push_back(int'(b_sel));
      end
      if (c_valid && c_irdy) begin
        q3_d.push_back(c_data[int'(c_sel)*64 +: 64]);
        q3_s.push_back(int'(c_sel));
      end
      tick();
    end
    chk("b_q_empty", q2_d.size(), 0);
    chk("c_q_empty", q3_d.size(), 0);
    chk("b_idle", b_ovalid, 0);
    chk("c_idle", c_ovalid, 0);
    chk("b_cnt", b_cnt, 0);
    chk("c_cnt", c_cnt, 0);
    chk("c_err", c_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
